// File: rtl/fifo_axis_drain.sv
// FIFO read port to framed AXI-stream master; one word is held back so TLAST can be attached.
// Optional idle-timeout packet close is enabled by defining FIFO_DRAIN_TIMEOUT_EN.
module fifo_axis_drain #(
  parameter int BW        = 8,
  parameter int LGPKT     = 4,
  parameter int LGTIMEOUT = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  output logic          o_fifo_rd,
  input  logic          i_fifo_empty,
  input  logic [BW-1:0] i_fifo_data,
  input  logic          i_flush,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [BW-1:0] o_data,
  output logic          o_last
);

  // State encoding doubles as the flags: bit 1 = output valid, bit 0 = hold valid.
  typedef enum logic [1:0] {
    S_EMPTY       = 2'b00,
    S_HOLD        = 2'b01,
    S_STREAM      = 2'b10,
    S_STREAM_HOLD = 2'b11
  } state_t;

  localparam logic [LGPKT-1:0] PKT_LAST = {LGPKT{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_h_data;
  logic [BW-1:0]     r_o_data;
  logic              r_o_last;
  logic [LGPKT-1:0]  r_beat_cnt;
  logic              r_flush_pend;

  logic w_h_valid;
  logic w_o_valid;
  logic w_out_free;
  logic w_close;
  logic w_move;
  logic w_pop;
  logic w_timeout_hit;
  logic w_h_nxt;
  logic w_o_nxt;

  assign w_h_valid  = r_state[0];
  assign w_o_valid  = r_state[1];
  assign w_out_free = !w_o_valid || i_ready;
  assign w_close    = (r_beat_cnt == PKT_LAST) || r_flush_pend || i_flush || w_timeout_hit;
  // A held word only leaves without a successor when it must close the packet.
  assign w_move     = w_h_valid && w_out_free && (!i_fifo_empty || w_close);
  assign w_pop      = !i_fifo_empty && (!w_h_valid || w_move);
  assign o_fifo_rd  = w_pop && i_reset_n;

  assign o_valid = w_o_valid;
  assign o_data  = r_o_data;
  assign o_last  = r_o_last;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode from the pop/move actions.
  always_comb begin
    w_h_nxt     = w_h_valid;
    w_o_nxt     = w_o_valid;
    w_state_nxt = r_state;
    if (w_pop) begin
      w_h_nxt = 1'b1;
    end else if (w_move) begin
      w_h_nxt = 1'b0;
    end else begin
      w_h_nxt = w_h_valid;
    end
    if (w_move) begin
      w_o_nxt = 1'b1;
    end else if (i_ready) begin
      w_o_nxt = 1'b0;
    end else begin
      w_o_nxt = w_o_valid;
    end
    case ({w_o_nxt, w_h_nxt})
      2'b00:   w_state_nxt = S_EMPTY;
      2'b01:   w_state_nxt = S_HOLD;
      2'b10:   w_state_nxt = S_STREAM;
      2'b11:   w_state_nxt = S_STREAM_HOLD;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Hold/output data, packet beat counter and retained flush request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_h_data     <= {BW{1'b0}};
      r_o_data     <= {BW{1'b0}};
      r_o_last     <= 1'b0;
      r_beat_cnt   <= {LGPKT{1'b0}};
      r_flush_pend <= 1'b0;
    end else begin
      if (w_pop) begin
        r_h_data <= i_fifo_data;
      end
      if (w_move) begin
        r_o_data   <= r_h_data;
        r_o_last   <= w_close;
        r_beat_cnt <= w_close ? {LGPKT{1'b0}} : r_beat_cnt + {{(LGPKT-1){1'b0}}, 1'b1};
      end
      // With nothing held there is no open packet to close, so the request is dropped.
      if ((w_move && w_close) || !w_h_valid) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] r_idle_cnt;

  assign w_timeout_hit = (r_idle_cnt == {LGTIMEOUT{1'b1}});

  // Idle counter: cycles a word sits in the hold register with the FIFO drained.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idle_cnt <= {LGTIMEOUT{1'b0}};
    end else if (w_move || !i_fifo_empty) begin
      r_idle_cnt <= {LGTIMEOUT{1'b0}};
    end else if (w_h_valid && !w_timeout_hit) begin
      r_idle_cnt <= r_idle_cnt + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Scoreboard bench for fifo_axis_drain (BW=8, LGPKT=2, LGTIMEOUT=3); timeout expectations
// follow FIFO_DRAIN_TIMEOUT_EN.
module tb_fifo_axis_drain;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       o_fifo_rd;
  logic       i_fifo_empty;
  logic [7:0] i_fifo_data;
  logic       i_flush;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_last;

  fifo_axis_drain #(.BW(8), .LGPKT(2), .LGTIMEOUT(3)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last)
  );

  always #5 i_clk = ~i_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         pops    = 0;
  int         pop_cyc = 0;
  int         rise_cyc = 0;
  int         acc_cnt = 0;
  int         acc_cyc[$];
  logic [7:0] fq[$];
  logic [8:0] sb[$];
  logic       rd_seen;
  logic       prev_valid, prev_stall, prev_last;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    i_fifo_empty = (fq.size() == 0);
    i_fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(first + 8'(i)));
    refresh();
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max) begin
      step();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_sb_le1(input int max);
    int n;
    n = 0;
    while (sb.size() > 1 && n < max) begin
      step();
      n++;
    end
    check("sb_le1_wait", 32'(sb.size() <= 1), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!o_valid && n < max) begin
      step();
      n++;
    end
    check(name, 32'(o_valid), 32'd1);
  endtask

  task automatic pulse_flush(output int at_cyc);
    i_flush = 1'b1;
    at_cyc  = cyc;
    step();
    i_flush = 1'b0;
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // FIFO model: a request seen mid-cycle pops the head at the following edge.
  initial forever begin
    @(negedge i_clk);
    rd_seen = o_fifo_rd;
    @(posedge i_clk);
    #1;
    if (rd_seen && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
      pop_cyc = cyc;
    end
    refresh();
  end

  // Monitor: scoreboard comparison on each handshake plus stall stability.
  initial forever begin
    logic [8:0] e;
    @(negedge i_clk);
    if (!i_reset_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_data", 32'(o_data), 32'(prev_data));
        check("stall_last", 32'(o_last), 32'(prev_last));
      end
      if (o_valid && !prev_valid) rise_cyc = cyc;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h last %0b expected no beat", o_data, o_last);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(o_data), 32'(e[7:0]));
          check("beat_last", 32'(o_last), 32'(e[8]));
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      prev_valid = o_valid;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, gaps, fc;
    i_reset_n = 1'b0;
    i_flush   = 1'b0;
    i_ready   = 1'b1;
    refresh();
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    push_words(8'hEE, 1);
    #1;
    check("rst_rd_forced0", 32'(o_fifo_rd), 32'd0);
    fq.delete();
    refresh();
    repeat (3) step();
    i_reset_n = 1'b1;
    step();

    // 1: two full packets back-to-back
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) expect_beat(8'(8'h10 + 8'(i)), (i == 3) || (i == 7));
    push_words(8'h10, 8);
    wait_drain("s1_drain", 40);
    gaps = 0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 1) gaps++;
    check("s1_beats", 32'(acc_cyc.size()), 32'd8);
    check("s1_gapfree", 32'(gaps), 32'd0);
    repeat (3) step();

    // 2/3: short packet left in the hold register
    expect_beat(8'hA0, 1'b0);
    expect_beat(8'hA1, 1'b0);
    expect_beat(8'hA2, 1'b1);
    push_words(8'hA0, 3);
`ifdef FIFO_DRAIN_TIMEOUT_EN
    wait_drain("s2_drain", 40);
    check("s2_timeout_latency", 32'(rise_cyc - pop_cyc), 32'd8);
`else
    repeat (20) step();
    check("s3_a2_held", 32'(sb.size()), 32'd1);
    check("s3_no_valid", 32'(o_valid), 32'd0);
    pulse_flush(fc);
    wait_drain("s3_drain", 10);
    check("s3_flush_latency", 32'(rise_cyc - fc), 32'd1);
`endif
    repeat (3) step();

    // 4: back-pressure for 5 cycles after the first beat appears
    i_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) expect_beat(8'(8'h30 + 8'(i)), (i == 3) || (i == 5));
    push_words(8'h30, 6);
    wait_valid("s4_first_valid", 20);
    repeat (4) step();
    check("s4_stall_pops", 32'(pops - p0), 32'd2);
    check("s4_stall_rd", 32'(o_fifo_rd), 32'd0);
    i_ready = 1'b1;
    wait_sb_le1(30);
    pulse_flush(fc);
    wait_drain("s4_drain", 20);
    repeat (3) step();

    // 5: reset in the middle of a packet
    a0 = acc_cnt;
    expect_beat(8'h40, 1'b0);
    expect_beat(8'h41, 1'b0);
    push_words(8'h40, 5);
    for (int n = 0; n < 20 && acc_cnt < a0 + 2; n++) step();
    check("s5_two_beats", 32'(acc_cnt - a0), 32'd2);
    i_reset_n = 1'b0;
    #1;
    check("s5_rst_valid", 32'(o_valid), 32'd0);
    check("s5_rst_data", 32'(o_data), 32'd0);
    check("s5_rst_last", 32'(o_last), 32'd0);
    check("s5_rst_rd", 32'(o_fifo_rd), 32'd0);
    fq.delete();
    refresh();
    repeat (2) step();
    i_reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) expect_beat(8'(8'h50 + 8'(i)), i == 3);
    push_words(8'h50, 4);
    wait_drain("s5_drain", 30);
    repeat (3) step();

    // 6: flush with no open packet is ignored
    pulse_flush(fc);
    repeat (2) step();
    check("s6_no_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 4; i++) expect_beat(8'(8'h60 + 8'(i)), i == 3);
    push_words(8'h60, 4);
    wait_drain("s6_drain", 30);
    repeat (3) step();

    // 7: flush during a stall is retained until the held word can move
    i_ready = 1'b0;
    expect_beat(8'h70, 1'b0);
    expect_beat(8'h71, 1'b1);
    expect_beat(8'h72, 1'b1);
    push_words(8'h70, 3);
    wait_valid("s7_first_valid", 20);
    step();
    pulse_flush(fc);
    repeat (2) step();
    i_ready = 1'b1;
    wait_sb_le1(20);
    pulse_flush(fc);
    wait_drain("s7_drain", 20);
    repeat (3) step();

    check("final_fifo_empty", 32'(fq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
